// File: rtl/seq_det_pkg.sv
// Shared state encoding for the 1-0-1 serial sequence detector.
// The testbench imports it to check the state register by name.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GOT1   = 2'b01,
    GOT10  = 2'b10,
    GOT101 = 2'b11
  } state_e;

endpackage

// File: rtl/seq101_det.sv
// Moore FSM detecting 1-0-1 on a serial bit stream; OVERLAP picks whether
// the final 1 of a match may also start the next one.
module seq101_det
  import seq_det_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic data_in,
  output logic data_out
);

  state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = data_in ? GOT1 : IDLE;
      GOT1:    state_nxt = data_in ? GOT1 : GOT10;
      GOT10:   state_nxt = data_in ? GOT101 : IDLE;
      // With overlap, the trailing 1 doubles as the start of "10".
      GOT101:  state_nxt = data_in ? GOT1 : (OVERLAP ? GOT10 : IDLE);
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded purely from the state flops, so data_in cannot glitch the flag.
  always_comb begin
    data_out = (state == GOT101);
  end

endmodule

// File: tb/tb_seq101_det.sv
// Self-checking bench for seq101_det: directed patterns plus a random stream
// scored against a shift-register model, for both OVERLAP settings.
module tb_seq101_det;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic data_in = 1'b0;
  logic out_ov, out_no;

  int checks = 0;
  int failures = 0;

  logic q_ov[$];
  logic q_no[$];

  seq101_det #(.OVERLAP(1'b1)) dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .data_out(out_ov)
  );

  seq101_det #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .rstn(rstn), .data_in(data_in), .data_out(out_no)
  );

  always #5 clk = ~clk;

  // One cycle: apply inputs, record expected flags, settle past the edge.
  task automatic drive(input logic r, input logic b, input logic e_ov, input logic e_no);
    rstn = r;
    data_in = b;
    q_ov.push_back(e_ov);
    q_no.push_back(e_no);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    data_in = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic e_ov, e_no;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      e_ov = q_ov.pop_front();
      e_no = q_no.pop_front();
      checks++;
      if (out_ov !== e_ov || out_no !== e_no) begin
        failures++;
        $display("FAIL reset_out cyc=%0d got=%b/%b exp=%b/%b", i, out_ov, out_no, e_ov, e_no);
      end
      checks++;
      if (dut.state !== IDLE || dut_no.state !== IDLE) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%0d/%0d exp=%0d", i, dut.state, dut_no.state, IDLE);
      end
    end
  endtask

  // Bits and expected pulses listed first-bit-first from the MSB.
  task automatic test_pattern(input string nm, input int n, input logic [15:0] bits,
                              input logic [15:0] exp_ov, input logic [15:0] exp_no);
    logic e_ov, e_no;
    do_reset();
    for (int i = 0; i < n; i++) begin
      drive(1'b1, bits[n-1-i], exp_ov[n-1-i], exp_no[n-1-i]);
      e_ov = q_ov.pop_front();
      e_no = q_no.pop_front();
      checks++;
      if (out_ov !== e_ov || out_no !== e_no) begin
        failures++;
        $display("FAIL %s bit=%0d got=%b/%b exp=%b/%b", nm, i + 1, out_ov, out_no, e_ov, e_no);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic e_ov, e_no;
    logic [5:0] r_seq = 6'b110111;
    logic [5:0] b_seq = 6'b100101;
    logic [5:0] x_seq = 6'b000001;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(r_seq[5-i], b_seq[5-i], x_seq[5-i], x_seq[5-i]);
      e_ov = q_ov.pop_front();
      e_no = q_no.pop_front();
      checks++;
      if (out_ov !== e_ov || out_no !== e_no) begin
        failures++;
        $display("FAIL reset_mid step=%0d got=%b/%b exp=%b/%b", i + 1, out_ov, out_no, e_ov, e_no);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] sh_ov = 3'b000;
    logic [2:0] sh_no = 3'b000;
    logic [2:0] nx;
    logic b, e_ov, e_no;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      b = 1'($urandom_range(0, 1));
      sh_ov = {sh_ov[1:0], b};
      nx = {sh_no[1:0], b};
      sh_no = (nx == 3'b101) ? 3'b000 : nx;
      drive(1'b1, b, sh_ov == 3'b101, nx == 3'b101);
      e_ov = q_ov.pop_front();
      e_no = q_no.pop_front();
      checks++;
      if (out_ov !== e_ov || out_no !== e_no) begin
        failures++;
        if (bad < 10)
          $display("FAIL random cyc=%0d got=%b/%b exp=%b/%b", i, out_ov, out_no, e_ov, e_no);
        bad++;
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_pattern("mixed", 16, 16'b0110010110100101, 16'b0000000100100001, 16'b0000000100100001);
    test_pattern("overlap", 5, 16'b10101, 16'b00101, 16'b00100);
    test_pattern("no_false_hit", 9, 16'b110011100, 16'b0, 16'b0);
    test_pattern("back_to_back", 7, 16'b1011011, 16'b0010010, 16'b0010010);
    test_pattern("ones_run", 4, 16'b1101, 16'b0001, 16'b0001);
    test_reset_mid();
    test_random();
    checks++;
    if (q_ov.size() != 0 || q_no.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d/%0d exp=0", q_ov.size(), q_no.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
